axil_reg_arbiter: RTL and testbench
===================================

Name: axil_reg_arbiter

Overview:
Shares one AXI4-Lite register master port between NUM_REQ independent register-access requesters, e.g. the RecoNIC config sequencer and the RDMA config/stat sequencer. Each requester issues single-beat read or write commands over a valid/ready command port. The arbiter grants round-robin, runs exactly one AXI-Lite transaction at a time, and returns read data and response to the granted requester as a one-cycle pulse. A sticky timeout flag reports a hung slave.

Parameters:
NUM_REQ, 2, number of requester ports (2..8)
ADDR_WIDTH, 32, AXI-Lite address width
DATA_WIDTH, 32, AXI-Lite data width
TIMEOUT_CYCLES, 1024, cycles waited on any single slave handshake before timeout_err sets

Ports:
axil_clk  in  1  clock
axil_rstn  in  1  synchronous active-low reset
req_valid  in  NUM_REQ  command valid, one bit per requester
req_ready  out  NUM_REQ  command accepted, one-hot or zero
req_wr  in  NUM_REQ  1 = write, 0 = read
req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses, requester i at slice i
req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data
rsp_valid  out  NUM_REQ  one-cycle completion pulse to the owning requester
rsp_rdata  out  DATA_WIDTH  read data, shared, valid with rsp_valid; 0 for writes
rsp_resp  out  2  bresp/rresp of the completed transaction
m_axil_awvalid/awaddr/awready  out/out/in  1/ADDR_WIDTH/1  AXI-Lite AW channel
m_axil_wvalid/wdata/wready  out/out/in  1/DATA_WIDTH/1  W channel (wstrb tied all-ones outside the block)
m_axil_bvalid/bresp/bready  in/in/out  1/2/1  B channel
m_axil_arvalid/araddr/arready  out/out/in  1/ADDR_WIDTH/1  AR channel
m_axil_rvalid/rdata/rresp/rready  in/in/in/out  1/DATA_WIDTH/2/1  R channel
busy  out  1  high in any state other than IDLE
timeout_err  out  1  sticky; cleared only by reset

Behaviour:
- Reset (axil_rstn low at a clock edge) drives every output to 0, state to IDLE, timeout counter to 0 and last_grant to NUM_REQ-1, so requester 0 wins first. Reset mid-transaction abandons the transaction immediately with no rsp_valid; the slave must be reset in the same domain.
- States: IDLE, WADDR (AW+W), WRESP, RADDR, RDATA, RESP.
- IDLE: req_ready is combinational, asserted only for the round-robin winner. The winner is the first i with req_valid[i], searching upward from last_grant+1 modulo NUM_REQ. On req_valid&req_ready, latch wr/addr/wdata and the grant index, update last_grant, then go to WADDR if write, else RADDR. req_ready is 0 in all other states.
- WADDR: awvalid and wvalid rise together in the first WADDR cycle. Each drops independently on its own ready handshake, and the two may complete in either order or in the same cycle. Go to WRESP once both are done. awaddr/wdata stay stable while their valid is high.
- WRESP: bready=1. On bvalid, capture bresp into rsp_resp, set rsp_rdata=0, go to RESP.
- RADDR: arvalid=1 until arready, then RDATA. RDATA: rready=1. On rvalid, capture rdata/rresp, go to RESP.
- RESP: rsp_valid[grant]=1 for exactly one cycle, then IDLE. The next grant can occur in that IDLE cycle.
- Minimum latency with zero-wait slave: accept at cycle 0, AW/W or AR handshake at cycle 1, B or R at cycle 2, rsp_valid at cycle 3. Back-to-back issue interval is 4 cycles.
- Timeout: counter clears on entry to each of WADDR, WRESP, RADDR and RDATA, and increments each cycle the awaited handshake is pending. When it reaches TIMEOUT_CYCLES-1, timeout_err sets. The FSM keeps waiting; it never aborts.
- Requester dropping req_valid without being granted is legal. A requester is not re-granted while its own transaction is in flight.
- Non-OKAY bresp/rresp is passed through unchanged. rsp_rdata holds its value outside rsp_valid.

Test Plan:
- Single write, req0 addr 0x0000_0010 data 0xDEAD_BEEF, zero-wait slave -> awaddr=0x10, wdata=0xDEADBEEF in cycle 1, rsp_valid=01 at cycle 3, rsp_resp=00, rsp_rdata=0.
- Single read, req1 addr 0x0000_0204, slave returns 0x1234_5678 after 5 wait cycles on rvalid -> rsp_valid=10 with rsp_rdata=0x12345678, busy high throughout.
- req0 and req1 both continuously valid for 4 commands each -> grant order 0,1,0,1,0,1,0,1, and no requester ever receives two consecutive grants while the other waits.
- awready 3 cycles before wready, and the reverse case -> awvalid/wvalid each drop the cycle after their own handshake, exactly one B wait, one rsp pulse.
- Slave returns bresp=2'b10 -> rsp_resp=2'b10. Slave never asserts arready with TIMEOUT_CYCLES=16 -> timeout_err=1 on the 16th pending cycle and stays 1 until reset.
- axil_rstn low during WRESP -> next cycle all outputs 0, state IDLE, no rsp_valid. After release, req0 is granted first.

Source files
------------

// File: rtl/axil_reg_arbiter.sv
// axil_reg_arbiter: round-robin sharing of one AXI4-Lite master port between NUM_REQ register requesters
module axil_reg_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                             axil_clk,
  input  logic                             axil_rstn,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ-1:0]               req_wr,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic [1:0]                       rsp_resp,
  output logic                             m_axil_awvalid,
  output logic [ADDR_WIDTH-1:0]            m_axil_awaddr,
  input  logic                             m_axil_awready,
  output logic                             m_axil_wvalid,
  output logic [DATA_WIDTH-1:0]            m_axil_wdata,
  input  logic                             m_axil_wready,
  input  logic                             m_axil_bvalid,
  input  logic [1:0]                       m_axil_bresp,
  output logic                             m_axil_bready,
  output logic                             m_axil_arvalid,
  output logic [ADDR_WIDTH-1:0]            m_axil_araddr,
  input  logic                             m_axil_arready,
  input  logic                             m_axil_rvalid,
  input  logic [DATA_WIDTH-1:0]            m_axil_rdata,
  input  logic [1:0]                       m_axil_rresp,
  output logic                             m_axil_rready,
  output logic                             busy,
  output logic                             timeout_err
);
  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA, RESP} state_t;
  state_t                state_q, state_d;
  logic [GW-1:0]         grant_q, grant_d, last_q, last_d, win, c;
  logic                  win_ok;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [1:0]            resp_q, resp_d;
  logic                  awvalid_q, awvalid_d, wvalid_q, wvalid_d, err_q, err_d;
  logic [CW-1:0]         cnt_q, cnt_d, cnt_inc;
  // round-robin winner: the lowest offset after last_q with a valid request wins
  always_comb begin
    win = '0;
    win_ok = 1'b0;
    c = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      c = GW'((int'(last_q) + k) % NUM_REQ);
      if (req_valid[c]) begin
        win = c;
        win_ok = 1'b1;
      end
    end
  end
  // next-state, datapath capture and timeout counting for the single in-flight transaction
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d = last_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    resp_d = resp_q;
    awvalid_d = awvalid_q & ~m_axil_awready;
    wvalid_d = wvalid_q & ~m_axil_wready;
    cnt_inc = (cnt_q == CW'(TIMEOUT_CYCLES - 1)) ? cnt_q : cnt_q + 1'b1;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (win_ok) begin
        grant_d = win;
        last_d = win;
        addr_d = req_addr[win*ADDR_WIDTH +: ADDR_WIDTH];
        wdata_d = req_wdata[win*DATA_WIDTH +: DATA_WIDTH];
        awvalid_d = req_wr[win];
        wvalid_d = req_wr[win];
        cnt_d = '0;
        state_d = req_wr[win] ? WADDR : RADDR;
      end
      WADDR: if (!awvalid_d && !wvalid_d) begin
        state_d = WRESP;
        cnt_d = '0;
      end else cnt_d = cnt_inc;
      WRESP: if (m_axil_bvalid) begin
        state_d = RESP;
        resp_d = m_axil_bresp;
        rdata_d = '0;
      end else cnt_d = cnt_inc;
      RADDR: if (m_axil_arready) begin
        state_d = RDATA;
        cnt_d = '0;
      end else cnt_d = cnt_inc;
      RDATA: if (m_axil_rvalid) begin
        state_d = RESP;
        resp_d = m_axil_rresp;
        rdata_d = m_axil_rdata;
      end else cnt_d = cnt_inc;
      default: state_d = IDLE;
    endcase
    err_d = err_q | (cnt_d == CW'(TIMEOUT_CYCLES - 1));
  end
  // state registers; reset abandons any transaction without a response
  always_ff @(posedge axil_clk) begin
    if (!axil_rstn) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q <= GW'(NUM_REQ - 1);
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      resp_q <= '0;
      awvalid_q <= 1'b0;
      wvalid_q <= 1'b0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q <= last_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      resp_q <= resp_d;
      awvalid_q <= awvalid_d;
      wvalid_q <= wvalid_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign req_ready = (state_q == IDLE && axil_rstn && win_ok) ? NUM_REQ'(1) << win : '0;
  assign rsp_valid = (state_q == RESP) ? NUM_REQ'(1) << grant_q : '0;
  assign rsp_rdata = rdata_q;
  assign rsp_resp = resp_q;
  assign m_axil_awvalid = awvalid_q;
  assign m_axil_awaddr = addr_q;
  assign m_axil_wvalid = wvalid_q;
  assign m_axil_wdata = wdata_q;
  assign m_axil_bready = state_q == WRESP;
  assign m_axil_arvalid = state_q == RADDR;
  assign m_axil_araddr = addr_q;
  assign m_axil_rready = state_q == RDATA;
  assign busy = state_q != IDLE;
  assign timeout_err = err_q;
endmodule

// File: tb/tb_axil_reg_arbiter.sv
// tb_axil_reg_arbiter: directed scenario tests for the AXI-Lite register arbiter
module tb_axil_reg_arbiter;
  logic        axil_clk = 1'b0, axil_rstn = 1'b0;
  logic [1:0]  req_valid = '0, req_wr = '0, req_ready, rsp_valid, rsp_resp;
  logic [63:0] req_addr = '0, req_wdata = '0;
  logic [31:0] rsp_rdata, awaddr, wdata, araddr;
  logic        awvalid, wvalid, bready, arvalid, rready, busy, timeout_err;
  logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
  logic [1:0]  bresp = '0, rresp = '0;
  logic [31:0] rdata = '0;
  int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  int          aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
  logic [1:0]  b_resp_v = '0;
  logic [31:0] r_data_v = 32'h1234_5678;
  bit          ar_hang = 0;
  int          rsp_cnt [2] = '{0, 0};
  int          nvec = 0, nerr = 0;

  axil_reg_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .axil_clk(axil_clk), .axil_rstn(axil_rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .m_axil_awvalid(awvalid), .m_axil_awaddr(awaddr), .m_axil_awready(awready),
    .m_axil_wvalid(wvalid), .m_axil_wdata(wdata), .m_axil_wready(wready),
    .m_axil_bvalid(bvalid), .m_axil_bresp(bresp), .m_axil_bready(bready),
    .m_axil_arvalid(arvalid), .m_axil_araddr(araddr), .m_axil_arready(arready),
    .m_axil_rvalid(rvalid), .m_axil_rdata(rdata), .m_axil_rresp(rresp), .m_axil_rready(rready),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 axil_clk = ~axil_clk;

  // slave model: each ready/valid rises after its configured number of wait cycles
  always @(negedge axil_clk) begin
    awready = awvalid && aw_cnt >= aw_dly;
    aw_cnt = awvalid ? aw_cnt + 1 : 0;
    wready = wvalid && w_cnt >= w_dly;
    w_cnt = wvalid ? w_cnt + 1 : 0;
    bvalid = bready && b_cnt >= b_dly;
    b_cnt = bready ? b_cnt + 1 : 0;
    bresp = b_resp_v;
    arready = arvalid && !ar_hang && ar_cnt >= ar_dly;
    ar_cnt = arvalid ? ar_cnt + 1 : 0;
    rvalid = rready && r_cnt >= r_dly;
    r_cnt = rready ? r_cnt + 1 : 0;
    rdata = r_data_v;
    rresp = 2'b00;
  end

  // response pulse counter per requester
  always @(posedge axil_clk) begin
    if (axil_rstn) begin
      if (rsp_valid[0]) rsp_cnt[0]++;
      if (rsp_valid[1]) rsp_cnt[1]++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic issue(input int r, input logic wr, input logic [31:0] a, input logic [31:0] d, output bit ok);
    @(negedge axil_clk);
    req_valid[r] = 1'b1;
    req_wr[r] = wr;
    req_addr[r*32 +: 32] = a;
    req_wdata[r*32 +: 32] = d;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (req_ready[r]) begin
        ok = 1;
        break;
      end
      @(negedge axil_clk);
    end
    @(negedge axil_clk);
    req_valid[r] = 1'b0;
  endtask

  task automatic wait_rsp(output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      #1;
      if (rsp_valid != 0) begin
        n = i;
        break;
      end
      @(negedge axil_clk);
    end
  endtask

  task automatic test_reset();
    req_valid = 2'b11;
    repeat (3) @(negedge axil_clk);
    #1;
    nvec++;
    if ({awvalid, wvalid, bready, arvalid, rready, busy, timeout_err, rsp_valid, req_ready, rsp_resp} !== '0) begin
      nerr++;
      $display("FAIL reset_ctrl got %b exp 0", {awvalid, wvalid, bready, arvalid, rready, busy, timeout_err, rsp_valid, req_ready, rsp_resp});
    end
    nvec++;
    if ((awaddr | wdata | araddr | rsp_rdata) !== 32'h0) begin
      nerr++;
      $display("FAIL reset_data got %h exp 0", awaddr | wdata | araddr | rsp_rdata);
    end
    @(negedge axil_clk);
    req_valid = 2'b00;
    axil_rstn = 1'b1;
    @(negedge axil_clk);
  endtask

  task automatic test_write();
    bit ok;
    issue(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, ok);
    nvec++;
    if (ok !== 1'b1) begin nerr++; $display("FAIL wr_grant got %b exp 1", ok); end
    #1;
    nvec++;
    if ({awvalid, wvalid, awaddr, wdata} !== {1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF}) begin
      nerr++;
      $display("FAIL wr_cycle1 got %b%b %h %h exp 11 00000010 deadbeef", awvalid, wvalid, awaddr, wdata);
    end
    @(negedge axil_clk); #1;
    nvec++;
    if ({awvalid, wvalid, bready} !== 3'b001) begin nerr++; $display("FAIL wr_cycle2 got %b exp 001", {awvalid, wvalid, bready}); end
    @(negedge axil_clk); #1;
    nvec++;
    if ({rsp_valid, rsp_resp, rsp_rdata} !== {2'b01, 2'b00, 32'h0}) begin
      nerr++;
      $display("FAIL wr_rsp got %b %b %h exp 01 00 00000000", rsp_valid, rsp_resp, rsp_rdata);
    end
    @(negedge axil_clk); #1;
    nvec++;
    if ({rsp_valid, busy} !== 3'b000) begin nerr++; $display("FAIL wr_done got %b exp 000", {rsp_valid, busy}); end
  endtask

  task automatic test_read();
    bit ok, bad;
    r_dly = 5;
    bad = 0;
    issue(1, 1'b0, 32'h0000_0204, 32'h0, ok);
    nvec++;
    if ({ok, arvalid, araddr} !== {1'b1, 1'b1, 32'h204}) begin
      nerr++;
      $display("FAIL rd_issue got %b%b %h exp 11 00000204", ok, arvalid, araddr);
    end
    for (int c = 1; c <= 7; c++) begin
      #1;
      if (!busy || rsp_valid != 0) bad = 1;
      @(negedge axil_clk);
    end
    nvec++;
    if (bad !== 1'b0) begin nerr++; $display("FAIL rd_busy got %b exp 0", bad); end
    #1;
    nvec++;
    if ({rsp_valid, rsp_resp, rsp_rdata} !== {2'b10, 2'b00, 32'h1234_5678}) begin
      nerr++;
      $display("FAIL rd_rsp got %b %b %h exp 10 00 12345678", rsp_valid, rsp_resp, rsp_rdata);
    end
    @(negedge axil_clk); #1;
    nvec++;
    if ({rsp_valid, busy, rsp_rdata} !== {3'b000, 32'h1234_5678}) begin
      nerr++;
      $display("FAIL rd_hold got %b %h exp 000 12345678", {rsp_valid, busy}, rsp_rdata);
    end
    r_dly = 0;
  endtask

  task automatic test_bresp();
    bit ok;
    int n;
    b_resp_v = 2'b10;
    issue(1, 1'b1, 32'h0000_0080, 32'h0000_0001, ok);
    wait_rsp(n);
    nvec++;
    if ({ok, rsp_valid, rsp_resp, rsp_rdata} !== {1'b1, 2'b10, 2'b10, 32'h0}) begin
      nerr++;
      $display("FAIL bresp got %b %b %b %h exp 1 10 10 00000000", ok, rsp_valid, rsp_resp, rsp_rdata);
    end
    nvec++;
    if (n !== 3) begin nerr++; $display("FAIL bresp_lat got %0d exp 3", n); end
    b_resp_v = 2'b00;
    @(negedge axil_clk);
  endtask

  task automatic test_back_to_back();
    int g [2];
    int order [$];
    int stamp [$];
    int r0, r1;
    bit bad;
    g = '{0, 0};
    r0 = rsp_cnt[0];
    r1 = rsp_cnt[1];
    bad = 0;
    req_wr = 2'b00;
    for (int c = 0; c < 100 && (g[0] < 4 || g[1] < 4); c++) begin
      @(negedge axil_clk);
      req_valid = {g[1] < 4, g[0] < 4};
      #1;
      if (req_ready[0]) begin order.push_back(0); stamp.push_back(c); g[0]++; end
      else if (req_ready[1]) begin order.push_back(1); stamp.push_back(c); g[1]++; end
    end
    @(negedge axil_clk);
    req_valid = 2'b00;
    repeat (6) @(negedge axil_clk);
    for (int k = 0; k < 8; k++) begin
      nvec++;
      if (k >= order.size() || order[k] != k % 2) begin
        nerr++;
        $display("FAIL rr_order[%0d] got %0d exp %0d", k, k < order.size() ? order[k] : -1, k % 2);
      end
    end
    for (int k = 1; k < stamp.size(); k++) if (stamp[k] - stamp[k-1] != 4) bad = 1;
    nvec++;
    if (bad !== 1'b0 || stamp.size() != 8) begin
      nerr++;
      $display("FAIL rr_interval got bad=%b n=%0d exp bad=0 n=8", bad, stamp.size());
    end
    nvec++;
    if (rsp_cnt[0] - r0 != 4 || rsp_cnt[1] - r1 != 4) begin
      nerr++;
      $display("FAIL rr_rsp got %0d/%0d exp 4/4", rsp_cnt[0] - r0, rsp_cnt[1] - r1);
    end
  endtask

  task automatic test_skew(input int awd, input int wd);
    bit ok, bad;
    int aw_low, w_low, bcyc, r0;
    aw_dly = awd;
    w_dly = wd;
    aw_low = -1;
    w_low = -1;
    bcyc = 0;
    bad = 0;
    r0 = rsp_cnt[0];
    issue(0, 1'b1, 32'h0000_0040, 32'hA5A5_0001, ok);
    for (int c = 1; c <= 12; c++) begin
      #1;
      if (!awvalid && aw_low < 0) aw_low = c;
      if (!wvalid && w_low < 0) w_low = c;
      if (bready) bcyc++;
      if ((awvalid && awaddr !== 32'h40) || (wvalid && wdata !== 32'hA5A5_0001)) bad = 1;
      @(negedge axil_clk);
    end
    nvec++;
    if ({ok, bad} !== 2'b10) begin nerr++; $display("FAIL skew_stable aw%0d_w%0d got %b exp 10", awd, wd, {ok, bad}); end
    nvec++;
    if (aw_low != awd + 2 || w_low != wd + 2) begin
      nerr++;
      $display("FAIL skew_drop aw%0d_w%0d got aw=%0d w=%0d exp aw=%0d w=%0d", awd, wd, aw_low, w_low, awd + 2, wd + 2);
    end
    nvec++;
    if (bcyc != 1 || rsp_cnt[0] - r0 != 1) begin
      nerr++;
      $display("FAIL skew_resp aw%0d_w%0d got b=%0d rsp=%0d exp b=1 rsp=1", awd, wd, bcyc, rsp_cnt[0] - r0);
    end
    aw_dly = 0;
    w_dly = 0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n, r0, r1;
    b_dly = 10;
    issue(0, 1'b1, 32'h0000_0100, 32'h0000_0055, ok);
    @(negedge axil_clk); #1;
    nvec++;
    if ({ok, bready} !== 2'b11) begin nerr++; $display("FAIL rmid_wresp got %b exp 11", {ok, bready}); end
    r0 = rsp_cnt[0];
    r1 = rsp_cnt[1];
    axil_rstn = 1'b0;
    @(negedge axil_clk); #1;
    nvec++;
    if ({awvalid, wvalid, bready, arvalid, rready, busy, timeout_err, rsp_valid, req_ready, rsp_resp} !== '0 ||
        (awaddr | wdata | araddr | rsp_rdata) !== 32'h0) begin
      nerr++;
      $display("FAIL rmid_zero got %b %h exp 0 0", {awvalid, wvalid, bready, arvalid, rready, busy, timeout_err, rsp_valid, req_ready, rsp_resp},
               awaddr | wdata | araddr | rsp_rdata);
    end
    b_dly = 0;
    axil_rstn = 1'b1;
    @(negedge axil_clk);
    req_wr = 2'b00;
    req_valid = 2'b11;
    #1;
    nvec++;
    if (req_ready !== 2'b01) begin nerr++; $display("FAIL rmid_first got %b exp 01", req_ready); end
    @(negedge axil_clk);
    req_valid = 2'b00;
    wait_rsp(n);
    nvec++;
    if (rsp_valid !== 2'b01 || n < 0) begin nerr++; $display("FAIL rmid_rsp got %b n=%0d exp 01", rsp_valid, n); end
    @(negedge axil_clk);
    nvec++;
    if (rsp_cnt[0] - r0 != 1 || rsp_cnt[1] - r1 != 0) begin
      nerr++;
      $display("FAIL rmid_count got %0d/%0d exp 1/0", rsp_cnt[0] - r0, rsp_cnt[1] - r1);
    end
  endtask

  task automatic test_timeout();
    bit ok, bad;
    int n;
    ar_hang = 1;
    bad = 0;
    issue(0, 1'b0, 32'h0000_0300, 32'h0, ok);
    for (int c = 1; c <= 16; c++) begin
      #1;
      if (c == 15) begin
        nvec++;
        if (timeout_err !== 1'b0) begin nerr++; $display("FAIL to_early got %b exp 0", timeout_err); end
      end
      if (c == 16) begin
        nvec++;
        if (timeout_err !== 1'b1) begin nerr++; $display("FAIL to_set got %b exp 1", timeout_err); end
      end
      if (c < 16) @(negedge axil_clk);
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge axil_clk); #1;
      if (!timeout_err || !busy || !arvalid) bad = 1;
    end
    nvec++;
    if ({ok, bad} !== 2'b10) begin nerr++; $display("FAIL to_wait got %b exp 10", {ok, bad}); end
    ar_hang = 0;
    wait_rsp(n);
    nvec++;
    if ({rsp_valid, timeout_err} !== 3'b011 || n < 0) begin
      nerr++;
      $display("FAIL to_finish got %b n=%0d exp 011", {rsp_valid, timeout_err}, n);
    end
    @(negedge axil_clk);
    axil_rstn = 1'b0;
    @(negedge axil_clk);
    axil_rstn = 1'b1;
    #1;
    nvec++;
    if (timeout_err !== 1'b0) begin nerr++; $display("FAIL to_clear got %b exp 0", timeout_err); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_bresp();
    test_back_to_back();
    test_skew(3, 0);
    test_skew(0, 3);
    test_reset_mid();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
